// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_cell.sv
// One-bit full subtractor built from gate primitives: d = a - b - bin.
// Ports: a, b, bin in; d (difference), bout (borrow out) out.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic ab_x;
  logic na;
  logic p0;
  logic p1;
  logic p2;

  xor g_x0 (ab_x, a, b);
  xor g_x1 (d, ab_x, bin);

  not g_n0 (na, a);

  and g_a0 (p0, na, b);
  and g_a1 (p1, na, bin);
  and g_a2 (p2, b, bin);

  or  g_o0 (bout, p0, p1, p2);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, start/busy/done handshake.
// Ports: clock, reset (sync, high), start, inA, inB in;
//        busy, done, diff, borrowOut out; overflow out with
//        SERIAL_SUB_OVERFLOW_EN (signed overflow of the last result).
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrowOut
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Holds the low WIDTH-1 result bits; the MSB comes straight
  // from the cell on the final cycle.
  logic [WIDTH-2:0] r_sr;
  logic [WIDTH-1:0] r_nxt;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic d;
  logic bout;
  logic last;
  logic load;
  logic step;
  logic fin;
  logic busy_n;
  logic done_n;

  full_subtractor_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .d    (d),
    .bout (bout)
  );

  assign last  = (cnt == CW'(WIDTH - 1));
  assign r_nxt = {d, r_sr};

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    fin     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          busy_n  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          fin     = 1'b1;
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          busy_n = 1'b1;
        end
      end
      DONE: begin
        // A start here restarts immediately, no idle bubble.
        if (start) begin
          load    = 1'b1;
          busy_n  = 1'b1;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_n;
      done <= done_n;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sr   <= inA;
      b_sr   <= inB;
      r_sr   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (step) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      r_sr   <= r_nxt[WIDTH-1:1];
      borrow <= bout;
      cnt    <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      diff      <= '0;
      borrowOut <= 1'b0;
    end else if (fin) begin
      diff      <= r_nxt;
      borrowOut <= bout;
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  // On the final cycle the shift regs expose the operand MSBs
  // and the cell output is the result MSB.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (fin) begin
      overflow <= (a_sr[0] ^ b_sr[0]) & (d ^ a_sr[0]);
    end
  end
`endif

endmodule
